// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the sequenced FIR controller.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Accumulator wide enough that NTAPS full-scale products never overflow.
   function automatic int unsigned acc_width(input int unsigned dw,
                                             input int unsigned cw,
                                             input int unsigned ntaps);
      return dw + cw + $clog2(ntaps) + 2;
   endfunction

   function automatic longint sat_max(input int unsigned ow);
      return (64'sd1 <<< (ow - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int unsigned ow);
      return -(64'sd1 <<< (ow - 1));
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply, clearable accumulator, and round/shift/saturate output stage.
module fir_mac_unit
   import fir_pkg::*;
#(
   parameter int unsigned NTAPS      = 63,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned COEF_WIDTH = 24,
   parameter int unsigned COEF_FRAC  = 23,
   parameter int unsigned OUT_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  run,
   input  logic                  fin,
   input  logic                  ok,
   input  logic [DATA_WIDTH-1:0] sample,
   input  logic [COEF_WIDTH-1:0] coef,
   output logic [OUT_WIDTH-1:0]  result,
   output logic                  result_valid
);

   localparam int unsigned PW = DATA_WIDTH + COEF_WIDTH;
   localparam int unsigned AW = acc_width(DATA_WIDTH, COEF_WIDTH, NTAPS);
   localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(OUT_WIDTH));
   localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(OUT_WIDTH));
   localparam logic signed [AW-1:0] HALF   = AW'(1) << (COEF_FRAC - 1);

   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum_c;
   logic signed [AW-1:0] rnd_c;
   logic signed [AW-1:0] shf_c;
   logic [OUT_WIDTH-1:0] sat_c;

   // The last product is still in flight during DONE, so it is folded in here.
   always_comb begin
      sum_c = acc + AW'(prod);
      rnd_c = sum_c + HALF;
      shf_c = rnd_c >>> COEF_FRAC;
      if (shf_c > SAT_HI) begin
         sat_c = OUT_WIDTH'(SAT_HI);
      end else if (shf_c < SAT_LO) begin
         sat_c = OUT_WIDTH'(SAT_LO);
      end else begin
         sat_c = OUT_WIDTH'(shf_c);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod         <= '0;
         acc          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= fin;
         if (clr) begin
            prod <= '0;
            acc  <= '0;
         end else if (run) begin
            prod <= ok ? PW'($signed(sample)) * PW'($signed(coef)) : '0;
            acc  <= sum_c;
         end
         if (fin) begin
            result <= sat_c;
         end
      end
   end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Single-MAC FIR controller: sample ring buffer, coefficient RAM, sequencing FSM and status flags.
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned NTAPS      = 63,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned COEF_WIDTH = 24,
   parameter int unsigned COEF_FRAC  = 23,
   parameter int unsigned OUT_WIDTH  = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       coef_wr_en,
   input  logic [$clog2(NTAPS)-1:0]   coef_wr_addr,
   input  logic [COEF_WIDTH-1:0]      coef_wr_data,
   output logic                       coef_wr_err,
   output logic [OUT_WIDTH-1:0]       data_out,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       overrun
);

   localparam int unsigned AW = $clog2(NTAPS);
   localparam int unsigned FW = $clog2(NTAPS + 1);

   logic [DATA_WIDTH-1:0] sample_mem [NTAPS];
   logic [COEF_WIDTH-1:0] coef_mem   [NTAPS];

   state_t          state, state_next;
   logic [AW-1:0]   wr_ptr, base, k;
   logic [FW-1:0]   fill;
   logic [AW-1:0]   tap_c, raddr_c;
   logic [AW:0]     diff_c;
   logic            accept_c, run_c, fin_c, last_c, coef_ok_c;
   logic [DATA_WIDTH-1:0] rd_sample;
   logic [COEF_WIDTH-1:0] rd_coef;
   logic            rd_ok;

   // Reads run one tap ahead of the multiplier; tap 0 is loaded at accept.
   assign last_c    = (k == AW'(NTAPS - 1));
   assign tap_c     = k + AW'(1);
   assign diff_c    = {1'b0, base} - {1'b0, tap_c};
   assign raddr_c   = diff_c[AW] ? AW'(diff_c + (AW+1)'(NTAPS)) : diff_c[AW-1:0];
   assign coef_ok_c = coef_wr_en && (state == IDLE) && (32'(coef_wr_addr) < NTAPS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      run_c      = 1'b0;
      fin_c      = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept_c   = 1'b1;
               state_next = MAC;
            end
         end
         MAC: begin
            run_c = 1'b1;
            if (last_c) begin
               state_next = DONE;
            end
         end
         DONE: begin
            fin_c      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         base        <= '0;
         k           <= '0;
         fill        <= '0;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         coef_wr_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         in_ready    <= (state_next == IDLE);
         busy        <= (state_next != IDLE);
         coef_wr_err <= coef_wr_en && !coef_ok_c;
         if (in_valid && !in_ready) begin
            overrun <= 1'b1;
         end
         if (accept_c) begin
            base   <= wr_ptr;
            wr_ptr <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + AW'(1);
            fill   <= (fill == FW'(NTAPS)) ? fill : fill + FW'(1);
            k      <= '0;
         end else if (run_c) begin
            k <= last_c ? '0 : tap_c;
         end
      end
   end

   // RAM contents survive reset; writes are gated so a reset edge wins over them.
   always_ff @(posedge clk) begin
      if (accept_c && rst_n) begin
         sample_mem[wr_ptr] <= data_in;
      end
      if (coef_ok_c && rst_n) begin
         coef_mem[coef_wr_addr] <= coef_wr_data;
      end
      if (accept_c) begin
         rd_sample <= data_in;
         rd_coef   <= (coef_ok_c && coef_wr_addr == '0) ? coef_wr_data : coef_mem[0];
         rd_ok     <= 1'b1;
      end else if (run_c && !last_c) begin
         rd_sample <= sample_mem[raddr_c];
         rd_coef   <= coef_mem[tap_c];
         rd_ok     <= (FW'(tap_c) < fill);
      end
   end

   fir_mac_unit #(
      .NTAPS      (NTAPS),
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .COEF_FRAC  (COEF_FRAC),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_mac (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (accept_c),
      .run          (run_c),
      .fin          (fin_c),
      .ok           (rd_ok),
      .sample       (rd_sample),
      .coef         (rd_coef),
      .result       (data_out),
      .result_valid (out_valid)
   );

endmodule
